// File: rtl/mem_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | mem_ctrl_pkg: shared encodings for the byte-serial memory controller|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_e;

    localparam logic [2:0] IF_BYTES = 3'd4;

    // Illegal size 3 falls into the word case.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_if.sv
// +--------------------------------------------------------------------+
// | mem_ctrl_if: requester (IF/MEM) and RAM port bundle for mem_ctrl   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface mem_ctrl_if #(parameter int ADDR_W = 32);

    logic              if_req_in;
    logic [31:0]       if_addr_in;
    logic              if_done_out;
    logic [31:0]       if_inst_out;
    logic              flush_in;
    logic              mem_load_in;
    logic              mem_store_in;
    logic [31:0]       mem_addr_in;
    logic [1:0]        mem_size_in;
    logic              mem_signed_in;
    logic [31:0]       mem_wdata_in;
    logic              mem_done_out;
    logic [31:0]       mem_rdata_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic              ram_wr_out;
    logic [7:0]        ram_dout_out;
    logic [7:0]        ram_din_in;

    modport slave (
        input  if_req_in, if_addr_in, flush_in,
        input  mem_load_in, mem_store_in, mem_addr_in, mem_size_in,
        input  mem_signed_in, mem_wdata_in, ram_din_in,
        output if_done_out, if_inst_out, mem_done_out, mem_rdata_out,
        output ram_addr_out, ram_wr_out, ram_dout_out
    );

    modport master (
        output if_req_in, if_addr_in, flush_in,
        output mem_load_in, mem_store_in, mem_addr_in, mem_size_in,
        output mem_signed_in, mem_wdata_in, ram_din_in,
        input  if_done_out, if_inst_out, mem_done_out, mem_rdata_out,
        input  ram_addr_out, ram_wr_out, ram_dout_out
    );

endinterface

`default_nettype wire

// File: rtl/mem_ctrl_ld_extend.sv
// +--------------------------------------------------------------------+
// | ld_extend: combinational byte/half/word load sign/zero extender    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ld_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_raw,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & i_raw[7]}},  i_raw[7:0]};
            SZ_HALF: o_data = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// +--------------------------------------------------------------------+
// | mem_ctrl: arbitrates IF/MEM onto one byte-wide synchronous RAM port|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic     clk_in,
    input  logic     rst_in,
    mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic              last_was_mem_q, last_was_mem_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0]        w_next_off;
    logic [1:0]        w_cap_sel;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_buf_cap;
    logic [31:0]       w_ext;
    logic              w_mem_req;
    logic              w_if_ok;
    logic              w_grant_if;

    // cnt_q counts edges since the grant: address cnt+1 is issued while byte cnt-1 arrives.
    assign w_next_off  = cnt_q + 3'd1;
    assign w_cap_sel   = cnt_q[1:0] - 2'd1;
    assign w_next_addr = base_q + ADDR_W'(w_next_off);
    assign w_mem_req   = bus.mem_load_in | bus.mem_store_in;
    assign w_if_ok     = bus.if_req_in & ~bus.flush_in;
    assign w_grant_if  = w_if_ok & (last_was_mem_q | ~w_mem_req);

    always_comb begin
        w_buf_cap = buf_q;
        w_buf_cap[{w_cap_sel, 3'b000} +: 8] = bus.ram_din_in;
    end

    ld_extend u_ld_extend (
        .i_raw    (w_buf_cap),
        .i_size   (size_q),
        .i_signed (signed_q),
        .o_data   (w_ext)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        nbytes_d       = nbytes_q;
        last_was_mem_d = last_was_mem_q;
        base_d         = base_q;
        addr_d         = addr_q;
        size_d         = size_q;
        signed_d       = signed_q;
        wdata_d        = wdata_q;
        buf_d          = buf_q;
        wr_d           = 1'b0;
        dout_d         = dout_q;
        if_done_d      = 1'b0;
        if_inst_d      = if_inst_q;
        mem_done_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                // A done cycle is a forced turnaround: no grant at this edge.
                if (!if_done_q && !mem_done_q) begin
                    if (w_grant_if) begin
                        state_d        = ST_IF_RD;
                        base_d         = bus.if_addr_in[ADDR_W-1:0];
                        addr_d         = bus.if_addr_in[ADDR_W-1:0];
                        nbytes_d       = IF_BYTES;
                        cnt_d          = 3'd0;
                        last_was_mem_d = 1'b0;
                    end else if (w_mem_req) begin
                        base_d         = bus.mem_addr_in[ADDR_W-1:0];
                        addr_d         = bus.mem_addr_in[ADDR_W-1:0];
                        nbytes_d       = size_bytes(bus.mem_size_in);
                        size_d         = size_e'(bus.mem_size_in);
                        signed_d       = bus.mem_signed_in;
                        wdata_d        = bus.mem_wdata_in;
                        cnt_d          = 3'd0;
                        last_was_mem_d = 1'b1;
                        if (bus.mem_store_in) begin
                            state_d = ST_MEM_WR;
                            wr_d    = 1'b1;
                            dout_d  = bus.mem_wdata_in[7:0];
                        end else begin
                            state_d = ST_MEM_RD;
                        end
                    end
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                if (state_q == ST_IF_RD && bus.flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    if (w_next_off < nbytes_q) begin
                        addr_d = w_next_addr;
                    end
                    if (cnt_q != 3'd0) begin
                        buf_d = w_buf_cap;
                    end
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_IF_RD) begin
                            if_done_d = 1'b1;
                            if_inst_d = w_buf_cap;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = w_ext;
                        end
                    end else begin
                        cnt_d = w_next_off;
                    end
                end
            end
            ST_MEM_WR: begin
                if (w_next_off < nbytes_q) begin
                    addr_d = w_next_addr;
                    dout_d = wdata_q[{w_next_off[1:0], 3'b000} +: 8];
                    wr_d   = 1'b1;
                    cnt_d  = w_next_off;
                end else begin
                    state_d    = ST_IDLE;
                    mem_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            nbytes_q       <= 3'd0;
            last_was_mem_q <= 1'b0;
            base_q         <= '0;
            addr_q         <= '0;
            size_q         <= SZ_BYTE;
            signed_q       <= 1'b0;
            wdata_q        <= 32'd0;
            buf_q          <= 32'd0;
            wr_q           <= 1'b0;
            dout_q         <= 8'd0;
            if_done_q      <= 1'b0;
            if_inst_q      <= 32'd0;
            mem_done_q     <= 1'b0;
            mem_rdata_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nbytes_q       <= nbytes_d;
            last_was_mem_q <= last_was_mem_d;
            base_q         <= base_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            wdata_q        <= wdata_d;
            buf_q          <= buf_d;
            wr_q           <= wr_d;
            dout_q         <= dout_d;
            if_done_q      <= if_done_d;
            if_inst_q      <= if_inst_d;
            mem_done_q     <= mem_done_d;
            mem_rdata_q    <= mem_rdata_d;
        end
    end

    assign bus.if_done_out   = if_done_q;
    assign bus.if_inst_out   = if_inst_q;
    assign bus.mem_done_out  = mem_done_q;
    assign bus.mem_rdata_out = mem_rdata_q;
    assign bus.ram_addr_out  = addr_q;
    assign bus.ram_wr_out    = wr_q;
    assign bus.ram_dout_out  = dout_q;

endmodule

`default_nettype wire
